// File: rtl/riscv_regfile_pkg.sv
// Shared types and defaults for the scrubbing RISC-V integer register file.
package riscv_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCRUB = 2'd1,
    DONE  = 2'd2
  } scrub_state_t;

  localparam int NR_OF_BITS = 32;
  localparam int NR_OF_REGS = 32;
  localparam int ADDR_BITS  = 5;
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_scrub_ctrl.sv
// Scrub sequencer, write-permit logic and debug read handshake for the register file.
module regfile_scrub_ctrl
  import riscv_regfile_pkg::*;
#(
  parameter int NrOfBits = NR_OF_BITS,
  parameter int NrOfRegs = NR_OF_REGS,
  parameter int AddrBits = ADDR_BITS
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                WrEn,
  input  logic [AddrBits-1:0] WrAddr,
  input  logic                ScrubReq,
  input  logic                DbgReq,
  input  logic [NrOfBits-1:0] dbg_rd_data,
  output logic                Busy,
  output logic                WrDropped,
  output logic                DbgAck,
  output logic [NrOfBits-1:0] DbgData,
  output logic                clear_en,
  output logic [AddrBits-1:0] clear_addr,
  output logic                wr_permit,
  output scrub_state_t        state
);

  localparam logic [AddrBits-1:0] LAST_ADDR = AddrBits'(NrOfRegs - 1);
  localparam logic [AddrBits-1:0] ZERO_ADDR = AddrBits'(REG_ZERO);

  logic                qtick;
  logic                wr_req;
  logic [AddrBits-1:0] counter;

  assign qtick      = ClockEnable & Tick;
  assign wr_req     = WrEn && (WrAddr != ZERO_ADDR);
  // A scrub request on an idle tick wins over the write of that same tick.
  assign wr_permit  = qtick && wr_req && (state == IDLE) && !ScrubReq;
  assign clear_en   = qtick && (state == SCRUB);
  assign clear_addr = counter;

  // Debug handshake is four-phase: DbgReq rises, DbgAck rises with DbgData
  // captured, DbgReq falls, DbgAck falls. DbgData is stable while DbgAck = 1.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      counter   <= '0;
      Busy      <= 1'b0;
      WrDropped <= 1'b0;
      DbgAck    <= 1'b0;
      DbgData   <= '0;
    end else if (qtick) begin
      WrDropped <= wr_req && ((state != IDLE) || ScrubReq);

      if (DbgAck && !DbgReq) begin
        DbgAck <= 1'b0;
      end else if (!DbgAck && DbgReq && (state == IDLE) && !ScrubReq) begin
        DbgAck  <= 1'b1;
        DbgData <= dbg_rd_data;
      end

      case (state)
        IDLE: begin
          if (ScrubReq) begin
            state   <= SCRUB;
            counter <= AddrBits'(1);
            Busy    <= 1'b1;
          end
        end
        SCRUB: begin
          counter <= counter + AddrBits'(1);
          if (counter == LAST_ADDR) state <= DONE;
        end
        DONE: begin
          state   <= IDLE;
          counter <= '0;
          Busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/riscv_regfile_scrub.sv
// 32-entry RISC-V integer register file with hardware scrub and debug read port.
module riscv_regfile_scrub
  import riscv_regfile_pkg::*;
#(
  parameter int NrOfBits = NR_OF_BITS,
  parameter int NrOfRegs = NR_OF_REGS,
  parameter int AddrBits = ADDR_BITS
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                WrEn,
  input  logic [AddrBits-1:0] WrAddr,
  input  logic [NrOfBits-1:0] WrData,
  input  logic [AddrBits-1:0] RdAddrA,
  output logic [NrOfBits-1:0] RdDataA,
  input  logic [AddrBits-1:0] RdAddrB,
  output logic [NrOfBits-1:0] RdDataB,
  input  logic                ScrubReq,
  output logic                Busy,
  output logic                WrDropped,
  input  logic                DbgReq,
  input  logic [AddrBits-1:0] DbgAddr,
  output logic                DbgAck,
  output logic [NrOfBits-1:0] DbgData
);

  localparam logic [AddrBits-1:0] ZERO_ADDR = AddrBits'(REG_ZERO);

  logic [NrOfBits-1:0] regs [NrOfRegs];
  logic                clear_en;
  logic [AddrBits-1:0] clear_addr;
  logic                wr_permit;
  logic [NrOfBits-1:0] dbg_rd_data;
  scrub_state_t        state;

  regfile_scrub_ctrl #(
    .NrOfBits(NrOfBits),
    .NrOfRegs(NrOfRegs),
    .AddrBits(AddrBits)
  ) u_ctrl (
    .Clock       (Clock),
    .Reset       (Reset),
    .ClockEnable (ClockEnable),
    .Tick        (Tick),
    .WrEn        (WrEn),
    .WrAddr      (WrAddr),
    .ScrubReq    (ScrubReq),
    .DbgReq      (DbgReq),
    .dbg_rd_data (dbg_rd_data),
    .Busy        (Busy),
    .WrDropped   (WrDropped),
    .DbgAck      (DbgAck),
    .DbgData     (DbgData),
    .clear_en    (clear_en),
    .clear_addr  (clear_addr),
    .wr_permit   (wr_permit),
    .state       (state)
  );

  // x0 is never a clear or write target, so it keeps its reset value of zero.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NrOfRegs; i++) regs[i] <= '0;
    end else if (clear_en) begin
      regs[clear_addr] <= '0;
    end else if (wr_permit) begin
      regs[WrAddr] <= WrData;
    end
  end

  // Operand buses are forced to zero while the file is partially scrubbed.
  assign RdDataA     = ((state != IDLE) || (RdAddrA == ZERO_ADDR)) ? '0 : regs[RdAddrA];
  assign RdDataB     = ((state != IDLE) || (RdAddrB == ZERO_ADDR)) ? '0 : regs[RdAddrB];
  assign dbg_rd_data = (DbgAddr == ZERO_ADDR) ? '0 : regs[DbgAddr];

endmodule

// File: tb/tb_riscv_regfile_scrub.sv
// Self-checking bench: directed vector table, multi-cycle sequences and random run vs a reference model.
module tb_riscv_regfile_scrub;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0, tick = 1'b0, wr_en = 1'b0;
  logic [4:0]  wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0, dbg_addr = '0;
  logic [31:0] wr_data = '0;
  logic        scrub_req = 1'b0, dbg_req = 1'b0;
  logic [31:0] rd_data_a, rd_data_b, dbg_data;
  logic        busy, wr_dropped, dbg_ack;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a scrub wipes the whole file at once and then stays busy for 32 ticks.
  logic [31:0] m_mem [32];
  int          m_busy_left;
  logic        m_drop, m_ack;
  logic [31:0] m_dd;

  typedef struct {
    logic ce, tk, we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic [4:0] ra, rb;
    logic dreq;
    logic [4:0] da;
    logic [31:0] e_ra, e_rb;
    logic e_ack;
    logic [31:0] e_dd;
  } vec_t;
  vec_t vecs [13];

  riscv_regfile_scrub dut (
    .Clock(clock), .Reset(reset), .ClockEnable(ce), .Tick(tick),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .RdAddrA(rd_addr_a), .RdDataA(rd_data_a),
    .RdAddrB(rd_addr_b), .RdDataB(rd_data_b),
    .ScrubReq(scrub_req), .Busy(busy), .WrDropped(wr_dropped),
    .DbgReq(dbg_req), .DbgAddr(dbg_addr), .DbgAck(dbg_ack), .DbgData(dbg_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_busy_left = 0;
    m_drop = 1'b0;
    m_ack  = 1'b0;
    m_dd   = '0;
  endtask

  task automatic model_tick();
    logic pre_busy, wr_req;
    pre_busy = (m_busy_left > 0);
    wr_req   = wr_en && (wr_addr != 5'd0);
    m_drop   = wr_req && (pre_busy || scrub_req);
    if (m_ack && !dbg_req) begin
      m_ack = 1'b0;
    end else if (!m_ack && dbg_req && !pre_busy && !scrub_req) begin
      m_dd  = m_mem[dbg_addr];
      m_ack = 1'b1;
    end
    if (pre_busy) m_busy_left--;
    else if (scrub_req) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_busy_left = 32;
    end else if (wr_req) m_mem[wr_addr] = wr_data;
  endtask

  task automatic check_model(input string tag);
    logic b;
    b = (m_busy_left > 0);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".wr_dropped"}, 32'(wr_dropped), 32'(m_drop));
    check({tag, ".dbg_ack"}, 32'(dbg_ack), 32'(m_ack));
    check({tag, ".dbg_data"}, dbg_data, m_dd);
    check({tag, ".rd_a"}, rd_data_a, b ? 32'd0 : m_mem[rd_addr_a]);
    check({tag, ".rd_b"}, rd_data_b, b ? 32'd0 : m_mem[rd_addr_b]);
  endtask

  // One clock edge; the model advances only when the edge is a qualified tick.
  task automatic step();
    @(posedge clock);
    if (ce && tick) model_tick();
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    ce = 1'b1; tick = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_model("reset");
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic run_out_scrub(input string tag);
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      step();
      check_model(tag);
      guard++;
    end
    check({tag, ".bound"}, 32'(guard < 100), 32'd1);
  endtask

  initial begin
    int cnt;
    // x5 and x9 hold values whose later overwrites the debug rows must not see.
    vecs[0]  = '{1, 1, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 0, 5'd0, 32'hDEADBEEF, 32'h0, 0, 32'h0};
    vecs[1]  = '{1, 1, 1, 5'd0, 32'h00001234, 5'd5, 5'd0, 0, 5'd0, 32'hDEADBEEF, 32'h0, 0, 32'h0};
    vecs[2]  = '{1, 0, 1, 5'd7, 32'h00000055, 5'd7, 5'd0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0};
    vecs[3]  = '{0, 1, 1, 5'd7, 32'h00000055, 5'd7, 5'd0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0};
    vecs[4]  = '{1, 1, 1, 5'd7, 32'h00000055, 5'd7, 5'd5, 0, 5'd0, 32'h55, 32'hDEADBEEF, 0, 32'h0};
    vecs[5]  = '{1, 1, 1, 5'd9, 32'h00000077, 5'd9, 5'd7, 0, 5'd0, 32'h77, 32'h55, 0, 32'h0};
    vecs[6]  = '{1, 1, 1, 5'd9, 32'h00000088, 5'd9, 5'd0, 1, 5'd9, 32'h88, 32'h0, 1, 32'h77};
    vecs[7]  = '{1, 1, 0, 5'd0, 32'h0, 5'd9, 5'd0, 1, 5'd9, 32'h88, 32'h0, 1, 32'h77};
    vecs[8]  = '{1, 1, 0, 5'd0, 32'h0, 5'd9, 5'd0, 0, 5'd9, 32'h88, 32'h0, 0, 32'h77};
    vecs[9]  = '{1, 1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd0, 32'h0, 32'h0, 1, 32'h0};
    vecs[10] = '{1, 1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0};
    vecs[11] = '{1, 1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd5, 32'h0, 32'h0, 1, 32'hDEADBEEF};
    vecs[12] = '{1, 1, 1, 5'd3, 32'h000000AA, 5'd0, 5'd3, 0, 5'd5, 32'h0, 32'hAA, 0, 32'hDEADBEEF};

    model_reset();
    #2;
    apply_reset();

    // Table-driven directed vectors.
    for (int i = 0; i < 13; i++) begin
      ce = vecs[i].ce; tick = vecs[i].tk; wr_en = vecs[i].we;
      wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      dbg_req = vecs[i].dreq; dbg_addr = vecs[i].da;
      step();
      check($sformatf("vec%0d.rd_a", i), rd_data_a, vecs[i].e_ra);
      check($sformatf("vec%0d.rd_b", i), rd_data_b, vecs[i].e_rb);
      check($sformatf("vec%0d.dbg_ack", i), 32'(dbg_ack), 32'(vecs[i].e_ack));
      check($sformatf("vec%0d.dbg_data", i), dbg_data, vecs[i].e_dd);
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'd0);
      check($sformatf("vec%0d.wr_dropped", i), 32'(wr_dropped), 32'd0);
    end
    wr_en = 1'b0; dbg_req = 1'b0;

    // Written value is invisible before its edge, visible after it.
    ce = 1'b1; tick = 1'b1; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h1111; rd_addr_a = 5'd10;
    #1;
    check("pre_edge.rd_a", rd_data_a, 32'h0);
    step();
    check("post_edge.rd_a", rd_data_a, 32'h1111);
    wr_en = 1'b0;

    // Full scrub with a dropped write on tick 4.
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
    check_model("filled");
    scrub_req = 1'b1;
    step();
    check_model("scrub_start");
    scrub_req = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      rd_addr_a = 5'($urandom_range(1, 31));
      rd_addr_b = 5'($urandom_range(0, 31));
      if (cnt == 4) begin wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA; end
      else wr_en = 1'b0;
      step();
      check_model("scrub");
      if (cnt == 4) check("scrub_drop_pulse", 32'(wr_dropped), 32'd1);
      if (cnt == 5) check("scrub_drop_clear", 32'(wr_dropped), 32'd0);
    end
    wr_en = 1'b0;
    check("scrub_busy_ticks", 32'(cnt), 32'd32);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      #1;
      check($sformatf("scrubbed_x%0d", i), rd_data_a, 32'h0);
    end

    // Same-tick scrub request and write.
    write_reg(5'd6, 32'h66);
    scrub_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h99;
    step();
    check("same_tick.wr_dropped", 32'(wr_dropped), 32'd1);
    check("same_tick.busy", 32'(busy), 32'd1);
    scrub_req = 1'b0; wr_en = 1'b0;
    run_out_scrub("same_tick_run");
    rd_addr_a = 5'd6;
    #1;
    check("same_tick.x6", rd_data_a, 32'h0);

    // Debug request during a scrub is deferred until back in IDLE.
    write_reg(5'd2, 32'h22);
    scrub_req = 1'b1;
    step();
    scrub_req = 1'b0; dbg_req = 1'b1; dbg_addr = 5'd2;
    run_out_scrub("dbg_defer");
    check("dbg_defer.ack_low", 32'(dbg_ack), 32'd0);
    step();
    check("dbg_defer.ack", 32'(dbg_ack), 32'd1);
    check("dbg_defer.data", dbg_data, 32'h0);
    dbg_req = 1'b0;
    step();
    check_model("dbg_release");

    // Asynchronous reset in the middle of a scrub with DbgAck high and a drop pulse.
    write_reg(5'd1, 32'h1234_5678);
    dbg_req = 1'b1; dbg_addr = 5'd1;
    step();
    check("mid.dbg_data", dbg_data, 32'h1234_5678);
    scrub_req = 1'b1;
    step();
    scrub_req = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      wr_en = (i == 10); wr_addr = 5'd8; wr_data = 32'h8;
      step();
    end
    check("mid.pre_busy", 32'(busy), 32'd1);
    check("mid.pre_drop", 32'(wr_dropped), 32'd1);
    wr_en = 1'b0; dbg_req = 1'b0;
    reset = 1'b1;
    #1;
    check("mid.busy", 32'(busy), 32'd0);
    check("mid.dbg_ack", 32'(dbg_ack), 32'd0);
    check("mid.wr_dropped", 32'(wr_dropped), 32'd0);
    check("mid.dbg_data0", dbg_data, 32'h0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    write_reg(5'd4, 32'h44);
    rd_addr_a = 5'd4;
    #1;
    check("post_reset.write", rd_data_a, 32'h44);
    check_model("post_reset");

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      ce        = ($urandom_range(0, 3) != 0);
      tick      = ($urandom_range(0, 3) != 0);
      wr_en     = $urandom_range(0, 1);
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = $urandom;
      rd_addr_a = 5'($urandom_range(0, 31));
      rd_addr_b = 5'($urandom_range(0, 31));
      scrub_req = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 2) == 0) dbg_req = ~dbg_req;
      dbg_addr  = 5'($urandom_range(0, 31));
      step();
      check_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
